spart_responder: RTL and testbench

- Peripheral end of the SPART processor bus: the bus-side responder, baud generator, UART transmitter and UART receiver.
- Decodes iocs/iorw/ioaddr cycles from the bus driver. Holds the 16-bit baud divisor, serialises written bytes on txd and deserialises rxd into a receive buffer.
- Reports tbr (transmit buffer ready) and rda (receive data available) back to the driver.
- Frame format: 8N1, LSB first, 16x oversampling.

---
 rtl/spart_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_spart_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spart_responder.sv
// ---------------------------------------------------------------------------
// spart_responder
//   Peripheral side of the SPART processor bus: bus decode, 16-bit baud
//   divisor, 8N1 UART transmitter and receiver with 16x oversampling.
//
// Ports
//   clk      system clock, all state on rising edge
//   rst      asynchronous active-high reset
//   iocs     chip select (one bus cycle per edge while high)
//   iorw     1 = read, 0 = write
//   ioaddr   00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//   databus  shared bidirectional data bus (driven only on reads of 0x)
//   rda      receive buffer holds an unread byte
//   tbr      transmitter can accept a byte
//   txd      serial out, idles high
//   rxd      serial in, asynchronous to clk
//
// Optional feature
//   SPART_ERR_FLAGS_EN : status bit 2 = framing error, bit 3 = overrun,
//                        both sticky and cleared by a status read.
//                        When undefined those bits read 0.
// ---------------------------------------------------------------------------
module spart_responder #(
   parameter logic [15:0] DEF_DIV     = 16'h0145,
   parameter int          SYNC_STAGES = 2          // must be >= 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // ---------------- bus decode ----------------
   logic rd_cyc, rd_rx, wr_tx, wr_dlo, wr_dhi;
   assign rd_cyc = iocs & iorw & ~ioaddr[1];
   assign rd_rx  = rd_cyc & ~ioaddr[0];
   assign wr_tx  = iocs & ~iorw & (ioaddr == 2'b00);
   assign wr_dlo = iocs & (ioaddr == 2'b10);
   assign wr_dhi = iocs & (ioaddr == 2'b11);

   // ---------------- baud generator ----------------
   logic [15:0] div_q, cnt_q, cnt_d, div_last;
   logic        tick;

   // div of 0 behaves as 1: counter never leaves 0 and ticks every clk
   assign div_last = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
   // >= keeps the counter bounded even if the divisor shrinks under it
   assign tick     = (cnt_q >= div_last);

   always_comb begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
      if (wr_dlo | wr_dhi) cnt_d = 16'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= DEF_DIV;
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
         if (wr_dlo) div_q[7:0]  <= databus;
         if (wr_dhi) div_q[15:8] <= databus;
      end
   end

   // ---------------- transmitter ----------------
   state_t      tx_state_q;
   logic [3:0]  tx_tcnt_q;
   logic [2:0]  tx_idx_q, tx_idx_nx;
   logic [7:0]  tx_buf_q;
   logic        txd_q, tbr_q;
   logic        tx_last, tx_done, tx_accept;

   assign tx_idx_nx = tx_idx_q + 3'd1;
   assign tx_last   = tick & (tx_tcnt_q == 4'hF);
   assign tx_done   = (tx_state_q == S_STOP) & tx_last;
   // a write on the very edge the frame finishes is taken, tbr stays low
   assign tx_accept = wr_tx & (tbr_q | tx_done);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_tcnt_q  <= 4'd0;
         tx_idx_q   <= 3'd0;
         tx_buf_q   <= 8'h00;
         txd_q      <= 1'b1;
         tbr_q      <= 1'b1;
      end else begin
         if (tx_accept) tx_buf_q <= databus;

         if (tx_accept)    tbr_q <= 1'b0;
         else if (tx_done) tbr_q <= 1'b1;

         case (tx_state_q)
            S_IDLE: begin
               // tbr low in IDLE means a byte is waiting to go out
               if (!tbr_q && tick) begin
                  tx_state_q <= S_START;
                  tx_tcnt_q  <= 4'd0;
                  txd_q      <= 1'b0;
               end
            end
            S_START: begin
               if (tick) tx_tcnt_q <= tx_tcnt_q + 4'd1;
               if (tx_last) begin
                  tx_state_q <= S_DATA;
                  tx_idx_q   <= 3'd0;
                  txd_q      <= tx_buf_q[0];
               end
            end
            S_DATA: begin
               if (tick) tx_tcnt_q <= tx_tcnt_q + 4'd1;
               if (tx_last) begin
                  tx_idx_q <= tx_idx_nx;
                  if (tx_idx_q == 3'd7) begin
                     tx_state_q <= S_STOP;
                     txd_q      <= 1'b1;
                  end else begin
                     txd_q <= tx_buf_q[tx_idx_nx];
                  end
               end
            end
            default: begin // S_STOP
               if (tick) tx_tcnt_q <= tx_tcnt_q + 4'd1;
               if (tx_last) tx_state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   state_t      rx_state_q;
   logic [3:0]  rx_tcnt_q;
   logic [2:0]  rx_idx_q;
   logic [7:0]  rx_sh_q, rx_buf_q;
   logic        rda_q;
   logic        rx_last, rx_stop_smp, rx_ok, rx_fe;

   assign rx_last     = tick & (rx_tcnt_q == 4'hF);
   assign rx_stop_smp = (rx_state_q == S_STOP) & rx_last;
   assign rx_ok       = rx_stop_smp & rx_s;
   assign rx_fe       = rx_stop_smp & ~rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= S_IDLE;
         rx_tcnt_q  <= 4'd0;
         rx_idx_q   <= 3'd0;
         rx_sh_q    <= 8'h00;
         rx_buf_q   <= 8'h00;
         rda_q      <= 1'b0;
      end else begin
         // completion beats a same-edge read: new byte is unread
         if (rx_ok)      rda_q <= 1'b1;
         else if (rd_rx) rda_q <= 1'b0;
         if (rx_ok) rx_buf_q <= rx_sh_q;

         case (rx_state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  rx_state_q <= S_START;
                  rx_tcnt_q  <= 4'd0;
               end
            end
            S_START: begin
               if (tick) begin
                  rx_tcnt_q <= rx_tcnt_q + 4'd1;
                  // half a bit in: re-check the line to reject glitches
                  if (rx_tcnt_q == 4'd7) begin
                     rx_tcnt_q  <= 4'd0;
                     rx_idx_q   <= 3'd0;
                     rx_state_q <= rx_s ? S_IDLE : S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (tick) rx_tcnt_q <= rx_tcnt_q + 4'd1;
               if (rx_last) begin
                  rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                  rx_idx_q <= rx_idx_q + 3'd1;
                  if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
               end
            end
            default: begin // S_STOP
               if (tick) rx_tcnt_q <= rx_tcnt_q + 4'd1;
               if (rx_last) rx_state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------- error flags ----------------
   logic [1:0] err_bits;
`ifdef SPART_ERR_FLAGS_EN
   logic fe_q, ov_q, rd_st;
   assign rd_st = rd_cyc & ioaddr[0];

   // setting wins over the clearing status read on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fe_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         if (rx_fe)      fe_q <= 1'b1;
         else if (rd_st) fe_q <= 1'b0;
         if (rx_ok && rda_q) ov_q <= 1'b1;
         else if (rd_st)     ov_q <= 1'b0;
      end
   end
   assign err_bits = {ov_q, fe_q};
`else
   assign err_bits = 2'b00;
`endif

   // ---------------- read path ----------------
   logic [7:0] rd_data;
   assign rd_data = ioaddr[0] ? {4'b0000, err_bits, tbr_q, rda_q} : rx_buf_q;
   assign databus = rd_cyc ? rd_data : 8'hzz;

   assign rda = rda_q;
   assign tbr = tbr_q;
   assign txd = txd_q;

endmodule

// File: tb/tb_spart_responder.sv
// ---------------------------------------------------------------------------
// tb_spart_responder
//   Directed stimulus with scoreboard checking. Bus reads push the expected
//   byte into rd_q, TX writes push the expected serial byte into tx_q; two
//   monitor processes pop and compare as the DUT presents data.
// ---------------------------------------------------------------------------
module tb_spart_responder;

   logic       clk, rst, iocs, iorw, rxd;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic [7:0] tb_drv;
   logic       tb_en;
   logic       rda, tbr, txd;

   int checks = 0;
   int errors = 0;

   logic [7:0] rd_q[$];
   logic [7:0] tx_q[$];

`ifdef SPART_ERR_FLAGS_EN
   localparam logic [7:0] ST_FE = 8'h06;
   localparam logic [7:0] ST_OV = 8'h0B;
`else
   localparam logic [7:0] ST_FE = 8'h02;
   localparam logic [7:0] ST_OV = 8'h03;
`endif

   assign databus = tb_en ? tb_drv : 8'hzz;

   spart_responder #(.DEF_DIV(16'h0145), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic rw, input logic [7:0] d);
      iocs = 1'b1; iorw = rw; ioaddr = a; tb_drv = d; tb_en = 1'b1;
      clks(1);
      iocs = 1'b0; iorw = 1'b0; tb_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [7:0] exp);
      rd_q.push_back(exp);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      clks(1);
      iocs = 1'b0; iorw = 1'b0;
   endtask

   // 8N1 frame at 64 clks/bit; a bad stop bit is held low for 48 clks only
   task automatic send_frame(input logic [7:0] b, input logic stopb);
      rxd = 1'b0; clks(64);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i]; clks(64);
      end
      rxd = stopb;
      clks(stopb ? 64 : 48);
      rxd = 1'b1; clks(80);
   endtask

   // bus read monitor
   initial begin : rd_mon
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (iocs && iorw && !ioaddr[1]) begin
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected got %h expected none", databus);
            end else begin
               e = rd_q.pop_front();
               if (databus !== e) begin
                  errors++;
                  $display("FAIL rd_addr%0d got %h expected %h", ioaddr, databus, e);
               end
            end
         end
      end
   end

   // txd frame monitor: samples bit centres relative to the start edge
   initial begin : tx_mon
      logic [7:0] got;
      logic       sb, st;
      int         n;
      forever begin
         @(negedge clk);
         if (!rst && txd == 1'b0) begin
            repeat (32) @(negedge clk);
            st = txd;
            for (int i = 0; i < 8; i++) begin
               repeat (64) @(negedge clk);
               got[i] = txd;
            end
            repeat (64) @(negedge clk);
            sb = txd;
            n  = 608;
            while (!tbr && n < 1000) begin
               @(negedge clk);
               n++;
            end
            chk("tx_start_bit", {31'd0, st}, 32'd0);
            chk("tx_stop_bit", {31'd0, sb}, 32'd1);
            chk("tx_tbr_delay", n, 640);
            checks++;
            if (tx_q.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected_frame got %h expected none", got);
            end else if (got !== tx_q[0]) begin
               errors++;
               $display("FAIL tx_byte got %h expected %h", got, tx_q[0]);
               void'(tx_q.pop_front());
            end else begin
               void'(tx_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      int w;
      rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
      tb_drv = 8'h00; tb_en = 1'b0; rxd = 1'b1;
      clks(3);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_tbr", {31'd0, tbr}, 32'd1);
      chk("rst_rda", {31'd0, rda}, 32'd0);
      rst = 1'b0;
      clks(2);
      bus_read(2'b01, 8'h02);
      bus_read(2'b00, 8'h00);

      // divisor = 4 -> 64 clks per bit
      bus_write(2'b10, 1'b1, 8'h04);
      bus_write(2'b11, 1'b1, 8'h00);

      // transmit A5; mid-frame write of 3C must be dropped
      tx_q.push_back(8'hA5);
      bus_write(2'b00, 1'b0, 8'hA5);
      chk("tbr_after_write", {31'd0, tbr}, 32'd0);
      clks(200);
      bus_read(2'b01, 8'h00);
      bus_write(2'b00, 1'b0, 8'h3C);
      w = 0;
      while (tx_q.size() != 0 && w < 2000) begin clks(1); w++; end
      chk("tx_frame_done", {31'd0, (tx_q.size() == 0)}, 32'd1);
      clks(800);
      chk("tbr_idle", {31'd0, tbr}, 32'd1);

      // receive 5A
      send_frame(8'h5A, 1'b1);
      chk("rda_5a", {31'd0, rda}, 32'd1);
      bus_read(2'b01, 8'h03);
      bus_read(2'b00, 8'h5A);
      chk("rda_cleared", {31'd0, rda}, 32'd0);
      bus_read(2'b01, 8'h02);

      // false start then framing error
      rxd = 1'b0; clks(20);
      rxd = 1'b1; clks(100);
      chk("rda_false_start", {31'd0, rda}, 32'd0);
      send_frame(8'hC3, 1'b0);
      chk("rda_framing", {31'd0, rda}, 32'd0);
      bus_read(2'b01, ST_FE);
      bus_read(2'b01, 8'h02);

      // overrun
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      chk("rda_overrun", {31'd0, rda}, 32'd1);
      bus_read(2'b01, ST_OV);
      bus_read(2'b00, 8'h22);
      bus_read(2'b01, 8'h02);

      clks(5);
      chk("rd_queue_empty", rd_q.size(), 32'd0);
      chk("tx_queue_empty", tx_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
